apb_master: RTL and testbench
=============================

# apb_master

APB requester that turns a simple valid/ready command interface into APB3 transfers toward peripherals such as the 32-word register slave. It runs one transfer at a time through IDLE → SETUP → ACCESS. It holds in ACCESS through any number of wait states and aborts with a timeout flag if `pready` never arrives. It returns one response pulse per command, carrying read data for reads.

## Interface
Parameters:
- `ADDR_W`, 32, width of `paddr` / `cmd_addr`
- `DATA_W`, 32, width of all data buses
- `TIMEOUT`, 16, number of ACCESS cycles with `pready`=0 before abort. 0 disables the timeout.

Ports:
- `pclk`  in  1  clock; all logic on the rising edge
- `preset`  in  1  reset; synchronous, active-high
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  transfer address
- `cmd_wdata`  in  DATA_W  write data
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  DATA_W  read data; valid only with `rsp_valid`
- `rsp_timeout`  out  1  qualifies `rsp_valid`: transfer aborted
- `psel`, `penable`, `pwrite`  out  1  APB control
- `paddr`  out  ADDR_W  APB address
- `pwdata`  out  DATA_W  APB write data
- `pready`  in  1  slave completion, may be combinational from `psel`/`penable`
- `prdata`  in  DATA_W  slave read data

## Operation
- FSM has 3 states, encoded as 2 bits:
  - **IDLE**: `psel`=0, `penable`=0, `cmd_ready`=1. On `cmd_valid`, latch `cmd_write`, `cmd_addr`, `cmd_wdata` into `pwrite`, `paddr`, `pwdata`, then go to SETUP.
  - **SETUP**: `psel`=1, `penable`=0, `cmd_ready`=0. Always goes to ACCESS next cycle.
  - **ACCESS**: `psel`=1, `penable`=1, `cmd_ready`=0.
    - `pready`=1: complete and go to IDLE.
    - `pready`=0 and wait count = TIMEOUT-1 (TIMEOUT≠0): abort and go to IDLE.
    - Otherwise: stay in ACCESS and increment the wait count.
- All APB outputs are registered. `paddr`, `pwdata` and `pwrite` are stable from SETUP through the last ACCESS cycle, and hold their values in IDLE until the next accept.
- Wait counter is clog2(TIMEOUT+1) bits wide. It is cleared on entry to ACCESS and never wraps.
- Completion registers these outputs for the next cycle:
  - `rsp_valid`=1 and `rsp_timeout`=0.
  - `rsp_rdata` = `prdata` for a read, 0 for a write.
- Abort registers these outputs for the next cycle:
  - `rsp_valid`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - `psel` and `penable` drop in that same next cycle.
- If `pready`=1 arrives in the expiry cycle, normal completion wins.
- `pready` and `prdata` are ignored outside ACCESS.
- `cmd_valid` while busy is not accepted; the command must be held by the requester.
- Reset, including mid-transfer, returns the FSM to IDLE and outputs no response for the killed transfer. All outputs reset to 0. `cmd_ready` is held 0 while `preset`=1.

## Timing
- Accept at edge N, i.e. `cmd_valid`&`cmd_ready` sampled high:
  - cycle N+1: SETUP
  - cycle N+2: first ACCESS
- With 0 wait states: `rsp_valid` in N+3, and `psel`=0 in N+3.
- Each wait cycle adds 1 cycle. Latency = 3 + waits.
- Timeout: `rsp_valid` and `rsp_timeout` appear in N+2+TIMEOUT.
- `cmd_ready` returns to 1 in the same cycle as `rsp_valid`. Peak throughput is 1 transfer per 3 cycles.
- `rsp_valid` is high for exactly 1 cycle per accepted command.

## Test plan
- Write then read, zero-wait slave:
  - write 0xDEADBEEF to 0x04 → `rsp_valid` at N+3 with `rsp_timeout`=0.
  - read 0x04 → `rsp_rdata`=0xDEADBEEF at N+3.
- Wait states: slave holds `pready`=0 for 3 ACCESS cycles on a read of 0x10 → `psel`/`penable` stay high through N+5, `rsp_valid` at N+6, `rsp_rdata` = `prdata` from N+5.
- Timeout with TIMEOUT=4 and `pready` tied 0 → `psel` high N+1..N+5, then `rsp_valid`=1, `rsp_timeout`=1, `rsp_rdata`=0 at N+6. A late `pready`=1 in IDLE is ignored.
- Back-to-back: `cmd_valid` held high for two writes (0x00←1, 0x01←2) → second SETUP at N+4, second `rsp_valid` at N+6. `paddr` is never changed during a transfer.
- Reset in ACCESS: assert `preset` for 1 cycle while `pready`=0 → next cycle `psel`=`penable`=`rsp_valid`=0 and `cmd_ready`=0, then `cmd_ready`=1 on release. No response is ever issued for the killed command.
- Expiry race: TIMEOUT=4 with `pready`=1 on the 4th ACCESS cycle → normal completion with `rsp_timeout`=0.

Source files
------------

// File: rtl/apb_master.sv
// APB3 requester: accepts one valid/ready command at a time and runs it as an
// IDLE -> SETUP -> ACCESS transfer, with an optional wait-state timeout.
module apb_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } state_e;

    localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] CntMax  = '1;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              cmd_ready_q;
    logic              latch_cmd;
    logic              rsp_valid_d;
    logic              rsp_timeout_d;
    logic [DATA_W-1:0] rsp_rdata_d;

    // Registered ready, forced low while reset is asserted.
    assign cmd_ready = cmd_ready_q & ~preset;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        latch_cmd     = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    latch_cmd = 1'b1;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                state_d = StAccess;
                cnt_d   = '0;
            end
            StAccess: begin
                // Completion takes priority over expiry in the same cycle.
                if (pready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                    if (!pwrite) begin
                        rsp_rdata_d = prdata;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
                    state_d       = StIdle;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= (state_d == StIdle);
            psel        <= (state_d != StIdle);
            penable     <= (state_d == StAccess);
            rsp_valid   <= rsp_valid_d;
            rsp_timeout <= rsp_timeout_d;
            rsp_rdata   <= rsp_rdata_d;
            if (latch_cmd) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master (TIMEOUT=4) against a small
// 32-word APB slave model with programmable wait states.
module tb_apb_master;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;

    int          checks   = 0;
    int          failures = 0;
    int          rsp_count = 0;

    // Slave model controls
    int unsigned waits;
    int unsigned acc_cnt;
    logic        tie_low;
    logic        force_ready;
    logic [31:0] mem [0:31];

    apb_master #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pready     (pready),
        .prdata     (prdata)
    );

    always #5 pclk = ~pclk;

    assign pready = (psel & penable & ~tie_low & (acc_cnt >= waits)) | force_ready;
    assign prdata = (psel & penable) ? mem[paddr[4:0]] : 32'h0;

    always @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            mem[8]  <= 32'h1111_2222;
            mem[16] <= 32'hA5A5_1234;
            acc_cnt <= 0;
        end else begin
            if (psel && penable && pready && pwrite) mem[paddr[4:0]] <= pwdata;
            acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
        end
        if (rsp_valid) rsp_count <= rsp_count + 1;
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a command and steps through the accept edge (now in SETUP).
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        chk("accept_ready", {63'd0, cmd_ready}, 64'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        preset      = 1'b1;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = 32'h0;
        cmd_wdata   = 32'h0;
        waits       = 0;
        tie_low     = 1'b0;
        force_ready = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_psel", {63'd0, psel}, 64'd0);
        chk("rst_penable", {63'd0, penable}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_paddr", {32'd0, paddr}, 64'd0);
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        preset = 1'b0;
        chk("rst_rel_ready0", {63'd0, cmd_ready}, 64'd0);
        step();
        chk("rst_rel_ready1", {63'd0, cmd_ready}, 64'd1);

        // Zero-wait write 0xDEADBEEF to 0x04
        issue(1'b1, 32'h04, 32'hDEAD_BEEF);
        chk("wr_setup_psel", {63'd0, psel}, 64'd1);
        chk("wr_setup_penable", {63'd0, penable}, 64'd0);
        chk("wr_setup_ready", {63'd0, cmd_ready}, 64'd0);
        chk("wr_setup_paddr", {32'd0, paddr}, 64'h04);
        chk("wr_setup_pwrite", {63'd0, pwrite}, 64'd1);
        chk("wr_setup_pwdata", {32'd0, pwdata}, 64'hDEAD_BEEF);
        step();
        chk("wr_access_penable", {63'd0, penable}, 64'd1);
        chk("wr_access_rsp", {63'd0, rsp_valid}, 64'd0);
        step();
        chk("wr_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("wr_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
        chk("wr_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        chk("wr_psel_low", {63'd0, psel}, 64'd0);
        chk("wr_ready_back", {63'd0, cmd_ready}, 64'd1);
        chk("wr_mem", {32'd0, mem[4]}, 64'hDEAD_BEEF);
        step();
        chk("wr_rsp_pulse", {63'd0, rsp_valid}, 64'd0);

        // Zero-wait read of 0x04
        issue(1'b0, 32'h04, 32'h0);
        step();
        step();
        chk("rd_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("rd_rsp_rdata", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);
        chk("rd_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
        step();

        // Three wait states on read of 0x10; pready lands on the expiry cycle
        waits = 3;
        issue(1'b0, 32'h10, 32'h0);
        for (int k = 2; k <= 5; k++) begin
            step();
            chk($sformatf("ws_psel_n%0d", k), {63'd0, psel}, 64'd1);
            chk($sformatf("ws_penable_n%0d", k), {63'd0, penable}, 64'd1);
            chk($sformatf("ws_rsp_n%0d", k), {63'd0, rsp_valid}, 64'd0);
            chk($sformatf("ws_paddr_n%0d", k), {32'd0, paddr}, 64'h10);
        end
        step();
        chk("ws_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("ws_rsp_rdata", {32'd0, rsp_rdata}, 64'hA5A5_1234);
        chk("ws_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
        waits = 0;
        step();

        // Timeout with pready tied low
        tie_low = 1'b1;
        issue(1'b0, 32'h08, 32'h0);
        chk("to_psel_n1", {63'd0, psel}, 64'd1);
        for (int k = 2; k <= 5; k++) begin
            step();
            chk($sformatf("to_psel_n%0d", k), {63'd0, psel}, 64'd1);
            chk($sformatf("to_rsp_n%0d", k), {63'd0, rsp_valid}, 64'd0);
        end
        step();
        chk("to_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("to_rsp_timeout", {63'd0, rsp_timeout}, 64'd1);
        chk("to_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        chk("to_psel_low", {63'd0, psel}, 64'd0);
        chk("to_penable_low", {63'd0, penable}, 64'd0);
        chk("to_ready_back", {63'd0, cmd_ready}, 64'd1);
        tie_low     = 1'b0;
        force_ready = 1'b1;
        step();
        chk("late_ready_rsp", {63'd0, rsp_valid}, 64'd0);
        chk("late_ready_psel", {63'd0, psel}, 64'd0);
        force_ready = 1'b0;

        // Back-to-back writes with cmd_valid held
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h00;
        cmd_wdata = 32'h1;
        chk("b2b_ready", {63'd0, cmd_ready}, 64'd1);
        step();
        cmd_addr  = 32'h01;
        cmd_wdata = 32'h2;
        chk("b2b_setup1_paddr", {32'd0, paddr}, 64'h00);
        chk("b2b_setup1_pwdata", {32'd0, pwdata}, 64'h1);
        step();
        chk("b2b_access1_paddr", {32'd0, paddr}, 64'h00);
        chk("b2b_access1_ready", {63'd0, cmd_ready}, 64'd0);
        step();
        chk("b2b_rsp1", {63'd0, rsp_valid}, 64'd1);
        chk("b2b_rsp1_ready", {63'd0, cmd_ready}, 64'd1);
        chk("b2b_rsp1_paddr", {32'd0, paddr}, 64'h00);
        step();
        cmd_valid = 1'b0;
        chk("b2b_setup2_psel", {63'd0, psel}, 64'd1);
        chk("b2b_setup2_penable", {63'd0, penable}, 64'd0);
        chk("b2b_setup2_paddr", {32'd0, paddr}, 64'h01);
        chk("b2b_setup2_pwdata", {32'd0, pwdata}, 64'h2);
        step();
        chk("b2b_access2_paddr", {32'd0, paddr}, 64'h01);
        step();
        chk("b2b_rsp2", {63'd0, rsp_valid}, 64'd1);
        chk("b2b_mem0", {32'd0, mem[0]}, 64'h1);
        chk("b2b_mem1", {32'd0, mem[1]}, 64'h2);
        step();

        // Reset while stalled in ACCESS
        tie_low = 1'b1;
        issue(1'b0, 32'h08, 32'h0);
        step();
        chk("kill_in_access", {63'd0, penable}, 64'd1);
        preset = 1'b1;
        chk("kill_ready_in_rst", {63'd0, cmd_ready}, 64'd0);
        step();
        chk("kill_psel", {63'd0, psel}, 64'd0);
        chk("kill_penable", {63'd0, penable}, 64'd0);
        chk("kill_rsp", {63'd0, rsp_valid}, 64'd0);
        chk("kill_ready", {63'd0, cmd_ready}, 64'd0);
        preset  = 1'b0;
        tie_low = 1'b0;
        chk("kill_rel_ready0", {63'd0, cmd_ready}, 64'd0);
        step();
        chk("kill_rel_ready1", {63'd0, cmd_ready}, 64'd1);
        chk("kill_rel_rsp", {63'd0, rsp_valid}, 64'd0);
        repeat (3) step();
        chk("rsp_pulse_count", 64'(rsp_count), 64'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
